// File: rtl/jtopl_wrseq_pkg.sv
// +----------------------------------------------------------------------------+
// | jtopl_wrseq_pkg                                                            |
// | Shared constants for the write sequencer: register map, strobe bit        |
// | positions, FSM state encoding and channel-to-group/subslot helpers.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package jtopl_wrseq_pkg;

    `include "jtopl_regmap.vh"

    // Bit positions inside the one-hot update-strobe vector
    localparam int c_STB_W      = 6;
    localparam int c_STB_MULT   = 0;
    localparam int c_STB_KSL_TL = 1;
    localparam int c_STB_AR_DR  = 2;
    localparam int c_STB_SL_RR  = 3;
    localparam int c_STB_FNUM   = 4;
    localparam int c_STB_FBCON  = 5;

    // Transaction FSM encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    // Channels are laid out three per group: ch = 3*group + sub
    function automatic logic [1:0] ch_group(input logic [3:0] ch);
        if (ch >= 4'd6)
            return 2'd2;
        else if (ch >= 4'd3)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [2:0] ch_sub(input logic [3:0] ch);
        case (ch)
            4'd0, 4'd3, 4'd6: return 3'd0;
            4'd1, 4'd4, 4'd7: return 3'd1;
            default:          return 3'd2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtopl_regmap.vh
// +----------------------------------------------------------------------------+
// | jtopl_regmap.vh                                                            |
// | Register-map base addresses of the OPL write port and the default number  |
// | of operator slots per register-file rotation. Included by the package so  |
// | every design file sees the same constants.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef JTOPL_REGMAP_VH
`define JTOPL_REGMAP_VH

// Operator register groups: base + offset 0x00..0x15
localparam logic [7:0] c_BASE_MULT   = 8'h20;
localparam logic [7:0] c_BASE_KSL_TL = 8'h40;
localparam logic [7:0] c_BASE_AR_DR  = 8'h60;
localparam logic [7:0] c_BASE_SL_RR  = 8'h80;
// Channel register groups: base + channel 0..8
localparam logic [7:0] c_BASE_FNUM   = 8'hA0;
localparam logic [7:0] c_BASE_BLK    = 8'hB0;
localparam logic [7:0] c_BASE_FBCON  = 8'hC0;

localparam int         c_SLOTS_DEFAULT = 18;

`endif

// File: rtl/jtopl_wrdec.sv
// +----------------------------------------------------------------------------+
// | jtopl_wrdec                                                                |
// | Combinational register-address decoder.                                   |
// |   addr   : register address byte                                          |
// |   valid  : address maps to a register-file update strobe                  |
// |   blk    : address is a block/fnum-high/key-on register (0xB0+ch)         |
// |   strobe : one-hot update strobe (zero when not valid)                    |
// |   group  : target group, sub : target subslot, ch : channel nibble        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtopl_wrdec
    import jtopl_wrseq_pkg::*;
(
    input  logic [7:0]         addr,
    output logic               valid,
    output logic               blk,
    output logic [c_STB_W-1:0] strobe,
    output logic [1:0]         group,
    output logic [2:0]         sub,
    output logic [3:0]         ch
);

    logic [7:0] w_op_base;
    logic [7:0] w_ch_base;
    logic       w_op_ok;
    logic       w_ch_ok;

    assign w_op_base = {addr[7:5], 5'b0_0000};
    assign w_ch_base = {addr[7:4], 4'b0000};
    // Offsets 0x00..0x15 minus 0x06/07/0E/0F: low triplet index 6 or 7 is a
    // hole, and offsets 0x18..0x1F are out of range.
    assign w_op_ok   = (addr[4:3] != 2'b11) && (addr[2:1] != 2'b11);
    assign w_ch_ok   = (addr[3:0] <= 4'd8);
    assign ch        = addr[3:0];

    always_comb begin
        strobe = '0;
        blk    = 1'b0;
        group  = 2'd0;
        sub    = 3'd0;
        if (w_op_ok) begin
            if (w_op_base == c_BASE_MULT)   strobe[c_STB_MULT]   = 1'b1;
            if (w_op_base == c_BASE_KSL_TL) strobe[c_STB_KSL_TL] = 1'b1;
            if (w_op_base == c_BASE_AR_DR)  strobe[c_STB_AR_DR]  = 1'b1;
            if (w_op_base == c_BASE_SL_RR)  strobe[c_STB_SL_RR]  = 1'b1;
            group = addr[4:3];
            sub   = addr[2:0];
        end
        if (w_ch_ok) begin
            if (w_ch_base == c_BASE_FNUM) begin
                strobe[c_STB_FNUM] = 1'b1;
                group = ch_group(addr[3:0]);
                sub   = ch_sub(addr[3:0]);
            end
            if (w_ch_base == c_BASE_FBCON) begin
                strobe[c_STB_FBCON] = 1'b1;
                group = ch_group(addr[3:0]);
                sub   = ch_sub(addr[3:0]);
            end
            if (w_ch_base == c_BASE_BLK)
                blk = 1'b1;
        end
    end

    assign valid = |strobe;

endmodule

`default_nettype wire

// File: rtl/jtopl_wrseq.sv
// +----------------------------------------------------------------------------+
// | jtopl_wrseq                                                                |
// | CPU write sequencer for the OPL register file. Address/data writes are    |
// | decoded into one update strobe that is held for one full slot rotation    |
// | (SLOTS cen cycles) so the time-multiplexed register file catches it.      |
// | A one-entry pending buffer lets a second write queue behind the active    |
// | one. Block/fnum-high/key-on writes are latched directly.                  |
// |   clk, rst, cen      : clock, sync reset, slot clock enable               |
// |   din, addr, we      : CPU write port (addr 0 = address, 1 = data)        |
// |   busy               : transaction active or pending                      |
// |   sel_group, sel_sub : register-file target, reg_din : data byte         |
// |   up_*               : one-hot update strobes                             |
// |   latch_fnum, keyon  : block/fnum-high latch and per-channel key-on       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtopl_wrseq
    import jtopl_wrseq_pkg::*;
#(
    parameter int SLOTS = c_SLOTS_DEFAULT,
    parameter int RATEW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic       addr,
    input  logic       we,
    output logic       busy,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_fnum,
    output logic       up_fbcon,
    output logic [7:0] reg_din,
    output logic [4:0] latch_fnum,
    output logic [8:0] keyon
);

    localparam logic [RATEW-1:0] c_CNT_LAST = RATEW'(SLOTS - 1);

    // Registered state
    logic [0:0]         r_state;
    logic [RATEW-1:0]   r_cnt;
    logic [7:0]         r_alatch;
    logic               r_pend_v;
    logic [7:0]         r_pend_addr;
    logic [7:0]         r_pend_data;
    logic [c_STB_W-1:0] r_stb;
    logic [1:0]         r_grp;
    logic [2:0]         r_sub;
    logic [7:0]         r_reg_din;
    logic               r_busy;
    logic [4:0]         r_latch_fnum;
    logic [8:0]         r_keyon;

    // Next-state values
    logic [0:0]         w_state_d;
    logic [RATEW-1:0]   w_cnt_d;
    logic [7:0]         w_alatch_d;
    logic               w_pend_v_d;
    logic [7:0]         w_pend_addr_d;
    logic [7:0]         w_pend_data_d;
    logic [c_STB_W-1:0] w_stb_d;
    logic [1:0]         w_grp_d;
    logic [2:0]         w_sub_d;
    logic [7:0]         w_reg_din_d;
    logic               w_busy_d;
    logic [4:0]         w_latch_fnum_d;
    logic [8:0]         w_keyon_d;

    // Decode of the live write (against the address latch)
    logic               w_live_valid;
    logic               w_live_blk;
    logic [c_STB_W-1:0] w_live_stb;
    logic [1:0]         w_live_grp;
    logic [2:0]         w_live_sub;
    logic [3:0]         w_live_ch;

    // Decode of the pending entry
    logic               w_pend_valid;
    logic               w_pend_blk;
    logic [c_STB_W-1:0] w_pend_stb;
    logic [1:0]         w_pend_grp;
    logic [2:0]         w_pend_sub;
    logic [3:0]         w_pend_ch;

    logic               w_wr;
    logic               w_blk_wr;
    logic               w_hold_end;

    jtopl_wrdec u_dec_live (
        .addr   (r_alatch),
        .valid  (w_live_valid),
        .blk    (w_live_blk),
        .strobe (w_live_stb),
        .group  (w_live_grp),
        .sub    (w_live_sub),
        .ch     (w_live_ch)
    );

    jtopl_wrdec u_dec_pend (
        .addr   (r_pend_addr),
        .valid  (w_pend_valid),
        .blk    (w_pend_blk),
        .strobe (w_pend_stb),
        .group  (w_pend_grp),
        .sub    (w_pend_sub),
        .ch     (w_pend_ch)
    );

    // Only strobe-producing addresses are ever pended, so these decode
    // outputs carry no information for the pending path.
    logic w_unused_pend;
    assign w_unused_pend = &{1'b0, w_pend_valid, w_pend_blk, w_pend_ch};

    assign w_wr       = we & addr & w_live_valid;
    assign w_blk_wr   = we & addr & w_live_blk;
    assign w_hold_end = (r_state == c_ST_HOLD) & cen & (r_cnt == c_CNT_LAST);
    assign w_alatch_d = (we & ~addr) ? din : r_alatch;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_pend_v_d    = r_pend_v;
        w_pend_addr_d = r_pend_addr;
        w_pend_data_d = r_pend_data;
        w_stb_d       = r_stb;
        w_grp_d       = r_grp;
        w_sub_d       = r_sub;
        w_reg_din_d   = r_reg_din;

        case (r_state)
            c_ST_IDLE: begin
                if (w_wr) begin
                    w_state_d   = c_ST_HOLD;
                    w_cnt_d     = '0;
                    w_stb_d     = w_live_stb;
                    w_grp_d     = w_live_grp;
                    w_sub_d     = w_live_sub;
                    w_reg_din_d = din;
                end
            end
            c_ST_HOLD: begin
                if (cen)
                    w_cnt_d = r_cnt + 1'b1;
                if (w_hold_end) begin
                    if (r_pend_v) begin
                        // Pending entry takes over without a gap; the slot it
                        // vacates can absorb a write arriving on this edge.
                        w_cnt_d     = '0;
                        w_stb_d     = w_pend_stb;
                        w_grp_d     = w_pend_grp;
                        w_sub_d     = w_pend_sub;
                        w_reg_din_d = r_pend_data;
                        w_pend_v_d  = w_wr;
                        if (w_wr) begin
                            w_pend_addr_d = r_alatch;
                            w_pend_data_d = din;
                        end
                    end else if (w_wr) begin
                        w_cnt_d     = '0;
                        w_stb_d     = w_live_stb;
                        w_grp_d     = w_live_grp;
                        w_sub_d     = w_live_sub;
                        w_reg_din_d = din;
                    end else begin
                        w_state_d = c_ST_IDLE;
                        w_cnt_d   = '0;
                        w_stb_d   = '0;
                    end
                end else if (w_wr && !r_pend_v) begin
                    w_pend_v_d    = 1'b1;
                    w_pend_addr_d = r_alatch;
                    w_pend_data_d = din;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
                w_stb_d   = '0;
            end
        endcase

        w_busy_d = (w_state_d == c_ST_HOLD) | w_pend_v_d;
    end

    assign w_latch_fnum_d = w_blk_wr ? din[4:0] : r_latch_fnum;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_keyon
            assign w_keyon_d[gi] = (w_blk_wr && (w_live_ch == 4'(gi))) ? din[5]
                                                                       : r_keyon[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_alatch     <= '0;
            r_pend_v     <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_stb        <= '0;
            r_grp        <= '0;
            r_sub        <= '0;
            r_reg_din    <= '0;
            r_busy       <= 1'b0;
            r_latch_fnum <= '0;
            r_keyon      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_alatch     <= w_alatch_d;
            r_pend_v     <= w_pend_v_d;
            r_pend_addr  <= w_pend_addr_d;
            r_pend_data  <= w_pend_data_d;
            r_stb        <= w_stb_d;
            r_grp        <= w_grp_d;
            r_sub        <= w_sub_d;
            r_reg_din    <= w_reg_din_d;
            r_busy       <= w_busy_d;
            r_latch_fnum <= w_latch_fnum_d;
            r_keyon      <= w_keyon_d;
        end
    end

    assign busy       = r_busy;
    assign sel_group  = r_grp;
    assign sel_sub    = r_sub;
    assign reg_din    = r_reg_din;
    assign up_mult    = r_stb[c_STB_MULT];
    assign up_ksl_tl  = r_stb[c_STB_KSL_TL];
    assign up_ar_dr   = r_stb[c_STB_AR_DR];
    assign up_sl_rr   = r_stb[c_STB_SL_RR];
    assign up_fnum    = r_stb[c_STB_FNUM];
    assign up_fbcon   = r_stb[c_STB_FBCON];
    assign latch_fnum = r_latch_fnum;
    assign keyon      = r_keyon;

endmodule

`default_nettype wire
